phase_scheduler: RTL and testbench
==================================

Name: phase_scheduler

Overview:
Phase scheduler for the intersection light sequencer. It latches side-road sensor, pedestrian walk and emergency requests, and selects the next light phase with its duration. It issues each phase to the sequencer over a valid/ready handshake, then waits for the sequencer's phase_done before issuing the next phase. A tick-based watchdog forces a latched flashing-fault mode if the sequencer stalls.

Parameters:
TBASE, 6, base green duration in ticks
TEXT, 3, extension / walk / emergency duration in ticks
TYEL, 2, yellow duration in ticks
WDOG, 20, ticks allowed in WAIT before fault; every computed duration and WDOG must be ≤31

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle pulse, 1 per second, from the clock divider
sensor  in  1  side-road vehicle present; any high cycle sets sensor_pend
walk  in  1  pedestrian button; any high cycle sets walk_pend
emerg_req  in  1  emergency preempt, level
night_mode  in  1  night flashing request, level
grant_ready  in  1  sequencer accepts the grant
phase_done  in  1  one-cycle pulse: the sequencer finished the current phase
grant_valid  out  1  grant_phase/grant_time are valid
grant_phase  out  3  0 G_r, 1 Y_r, 2 R_g, 3 R_y, 4 R_r (walk), 5 FLASH, 6 EMERG
grant_time  out  5  phase duration in ticks
cur_phase  out  3  last accepted phase
pending  out  3  {emerg_req, walk_pend, sensor_pend}
fault  out  1  watchdog fault, latched until reset

Behaviour:
- Reset (async) values:
  - grant_valid=0, grant_phase=3, grant_time=0, cur_phase=3, fault=0.
  - sensor_pend=0, walk_pend=0, wdog count=0, state=ISSUE_INIT.
- First cycle after reset release: grant_valid=1, grant_phase=R_y, grant_time=TYEL.
- FSM states:
  - ISSUE: grant_valid=1.
    - Grant fields stay stable until grant_valid & grant_ready at a clock edge.
    - On that edge: cur_phase updates, then go to WAIT (or FAULT_WAIT if fault=1).
  - WAIT: grant_valid=0; wdog counts tick pulses.
    - phase_done: decide the next phase; grant_valid=1 in the following cycle (1-cycle latency); go to ISSUE.
    - wdog reaches WDOG before phase_done: fault←1; issue FLASH/1.
  - FAULT: always issue FLASH, grant_time=1; watchdog disabled; only reset exits.
- phase_done is ignored in ISSUE and in the accept cycle. phase_done coincident with the WDOG-th tick: done wins.
- Next-phase decision uses the completed phase P. Priority is emerg_req > night_mode > normal.
  - emerg_req:
    - P=G_r → Y_r/TYEL; P=R_g → R_y/TYEL.
    - Otherwise EMERG/TEXT, re-issued while emerg_req stays high.
    - EMERG with emerg_req low → G_r.
  - night_mode:
    - P=G_r → Y_r; P=R_g → R_y.
    - Otherwise FLASH/1, repeated while night_mode stays high.
    - FLASH with night_mode low → R_y/TYEL.
  - normal:
    - G_r → Y_r/TYEL.
    - Y_r → R_r/TEXT if walk_pend, else R_g.
    - R_r → R_g.
    - R_g → R_y/TYEL.
    - R_y → G_r.
- Durations:
  - G_r: TBASE+TEXT if sensor_pend, else 2*TBASE.
  - R_g: TBASE+TEXT if sensor_pend, else TBASE.
  - All sums computed at 5-bit width, no wrap (parameter limit above).
- Request latching:
  - walk_pend clears on acceptance of R_r; sensor_pend clears on acceptance of R_g.
  - A request high in the same cycle as its clearing acceptance is retained (set wins).
  - EMERG and FLASH phases do not clear pending requests.
- Reset mid-operation: immediate return to reset values; the in-flight grant is abandoned.

Decomposition:
- traffic_pkg holds:
  - light codes (off 0, green 1, yellow 2, red 3)
  - phase codes 0–6
  - default TBASE/TEXT/TYEL/WDOG
- One sub-module, phase_watchdog: tick counter with clear, enable and expire output.

Test Plan:
1. Release reset, grant_ready=1, phase_done 1 cycle after each accept → grants R_y/2, G_r/12, Y_r/2, R_g/6, R_y/2, G_r/12.
2. Hold grant_ready=0 for 5 cycles with walk pulsing → grant fields constant, grant_valid=1. Walk pulse during G_r WAIT → after Y_r: R_r/3, then R_g/6; pending[1] clears on R_r accept.
3. Sensor pulse during Y_r WAIT → R_g/9 and, later, G_r/9. Sensor pulse in the R_g accept cycle → pending[0] stays 1.
4. emerg_req high during R_g WAIT → R_y/2, then EMERG/3 repeated; drop emerg_req → G_r/12. night_mode high during G_r → Y_r, FLASH/1 repeated; drop → R_y/2.
5. Accept a grant, withhold phase_done for 20 ticks → fault=1 on the 20th tick; subsequent grants FLASH/1 regardless of inputs. Assert reset mid-WAIT → outputs at reset values asynchronously.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and defaults for the intersection light sequencer blocks.
// Phase codes double as the grant_phase / cur_phase wire encoding.
package traffic_pkg;

    typedef enum logic [1:0] {
        L_OFF    = 2'd0,
        L_GREEN  = 2'd1,
        L_YELLOW = 2'd2,
        L_RED    = 2'd3
    } light_t;

    // Named main-road / side-road: G_R is main green, side red, etc.
    typedef enum logic [2:0] {
        PH_G_R   = 3'd0,
        PH_Y_R   = 3'd1,
        PH_R_G   = 3'd2,
        PH_R_Y   = 3'd3,
        PH_R_R   = 3'd4,
        PH_FLASH = 3'd5,
        PH_EMERG = 3'd6
    } phase_t;

    typedef enum logic [1:0] {
        S_ISSUE_INIT,
        S_ISSUE,
        S_WAIT,
        S_FAULT_WAIT
    } sched_state_t;

    typedef struct packed {
        phase_t     phase;
        logic [4:0] dur;
    } grant_t;

    localparam int TBASE_DEF = 6;
    localparam int TEXT_DEF  = 3;
    localparam int TYEL_DEF  = 2;
    localparam int WDOG_DEF  = 20;

    function automatic grant_t mk_grant(input phase_t p, input logic [4:0] d);
        grant_t g;
        g.phase = p;
        g.dur   = d;
        return g;
    endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Counts tick pulses while enabled; expire fires on the tick that reaches WDOG.
module phase_watchdog #(
    parameter int WDOG = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [4:0] cnt;

    assign expire = en && (cnt == 5'(WDOG - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expire)
            cnt <= cnt + 5'd1;
    end

endmodule

// File: rtl/phase_scheduler.sv
// Picks the next light phase, issues it over valid/ready, then waits for
// phase_done; a stalled sequencer trips a latched flashing fault.
module phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TBASE = TBASE_DEF,
    parameter int TEXT  = TEXT_DEF,
    parameter int TYEL  = TYEL_DEF,
    parameter int WDOG  = WDOG_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       sensor,
    input  logic       walk,
    input  logic       emerg_req,
    input  logic       night_mode,
    input  logic       grant_ready,
    input  logic       phase_done,
    output logic       grant_valid,
    output logic [2:0] grant_phase,
    output logic [4:0] grant_time,
    output logic [2:0] cur_phase,
    output logic [2:0] pending,
    output logic       fault
);

    localparam logic [4:0] D_TYEL   = 5'(TYEL);
    localparam logic [4:0] D_TEXT   = 5'(TEXT);
    localparam logic [4:0] D_SENSED = 5'(TBASE + TEXT);
    localparam logic [4:0] D_G_BASE = 5'(2 * TBASE);
    localparam logic [4:0] D_R_BASE = 5'(TBASE);
    localparam logic [4:0] D_FLASH  = 5'd1;

    sched_state_t state_q, state_d;
    grant_t       grant_q, grant_d, next_g;
    logic         valid_q, valid_d;
    logic         fault_q, fault_d;
    phase_t       cur_q;
    logic         sensor_pend, walk_pend;
    logic         accept, expire;
    logic [4:0]   g_dur, rg_dur;

    assign accept = valid_q & grant_ready;

    phase_watchdog #(.WDOG(WDOG)) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (state_q != S_WAIT),
        .en     (tick && (state_q == S_WAIT)),
        .expire (expire)
    );

    // Successor of the phase that just completed.
    always_comb begin
        g_dur  = sensor_pend ? D_SENSED : D_G_BASE;
        rg_dur = sensor_pend ? D_SENSED : D_R_BASE;
        next_g = mk_grant(PH_R_Y, D_TYEL);
        if (emerg_req) begin
            case (cur_q)
                PH_G_R:  next_g = mk_grant(PH_Y_R, D_TYEL);
                PH_R_G:  next_g = mk_grant(PH_R_Y, D_TYEL);
                default: next_g = mk_grant(PH_EMERG, D_TEXT);
            endcase
        end else if (night_mode) begin
            case (cur_q)
                PH_G_R:  next_g = mk_grant(PH_Y_R, D_TYEL);
                PH_R_G:  next_g = mk_grant(PH_R_Y, D_TYEL);
                default: next_g = mk_grant(PH_FLASH, D_FLASH);
            endcase
        end else begin
            case (cur_q)
                PH_G_R:   next_g = mk_grant(PH_Y_R, D_TYEL);
                PH_Y_R:   next_g = walk_pend ? mk_grant(PH_R_R, D_TEXT)
                                             : mk_grant(PH_R_G, rg_dur);
                PH_R_R:   next_g = mk_grant(PH_R_G, rg_dur);
                PH_R_G:   next_g = mk_grant(PH_R_Y, D_TYEL);
                PH_R_Y:   next_g = mk_grant(PH_G_R, g_dur);
                PH_EMERG: next_g = mk_grant(PH_G_R, g_dur);
                default:  next_g = mk_grant(PH_R_Y, D_TYEL);
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        grant_d = grant_q;
        fault_d = fault_q;
        case (state_q)
            S_ISSUE_INIT: begin
                state_d = S_ISSUE;
                valid_d = 1'b1;
                grant_d = mk_grant(PH_R_Y, D_TYEL);
            end
            S_ISSUE: begin
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = fault_q ? S_FAULT_WAIT : S_WAIT;
                end
            end
            S_WAIT: begin
                // done beats a same-cycle watchdog expiry
                if (phase_done) begin
                    valid_d = 1'b1;
                    grant_d = next_g;
                    state_d = S_ISSUE;
                end else if (expire) begin
                    fault_d = 1'b1;
                    valid_d = 1'b1;
                    grant_d = mk_grant(PH_FLASH, D_FLASH);
                    state_d = S_ISSUE;
                end
            end
            S_FAULT_WAIT: begin
                if (phase_done) begin
                    valid_d = 1'b1;
                    grant_d = mk_grant(PH_FLASH, D_FLASH);
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_ISSUE_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_ISSUE_INIT;
            valid_q <= 1'b0;
            grant_q <= mk_grant(PH_R_Y, 5'd0);
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            fault_q <= fault_d;
        end
    end

    // A request arriving in its own clearing cycle is kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q       <= PH_R_Y;
            sensor_pend <= 1'b0;
            walk_pend   <= 1'b0;
        end else begin
            if (accept)
                cur_q <= grant_q.phase;
            sensor_pend <= sensor | (sensor_pend & ~(accept && grant_q.phase == PH_R_G));
            walk_pend   <= walk | (walk_pend & ~(accept && grant_q.phase == PH_R_R));
        end
    end

    assign grant_valid = valid_q;
    assign grant_phase = grant_q.phase;
    assign grant_time  = grant_q.dur;
    assign cur_phase   = cur_q;
    assign pending     = {emerg_req, walk_pend, sensor_pend};
    assign fault       = fault_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Bench for phase_scheduler: directed literal sequences plus randomized traffic
// checked every cycle against a transaction-level model of the phase rules.
module tb_phase_scheduler;

    localparam int TBASE = 6;
    localparam int TEXT  = 3;
    localparam int TYEL  = 2;
    localparam int WDOG  = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0, sensor = 1'b0, walk = 1'b0;
    logic       emerg_req = 1'b0, night_mode = 1'b0;
    logic       grant_ready = 1'b0, phase_done = 1'b0;
    logic       grant_valid, fault;
    logic [2:0] grant_phase, cur_phase, pending;
    logic [4:0] grant_time;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 0;

    phase_scheduler #(.TBASE(TBASE), .TEXT(TEXT), .TYEL(TYEL), .WDOG(WDOG)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .sensor      (sensor),
        .walk        (walk),
        .emerg_req   (emerg_req),
        .night_mode  (night_mode),
        .grant_ready (grant_ready),
        .phase_done  (phase_done),
        .grant_valid (grant_valid),
        .grant_phase (grant_phase),
        .grant_time  (grant_time),
        .cur_phase   (cur_phase),
        .pending     (pending),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Phase rule table: emergency > night > normal cycle.
    function automatic void decide(input int p, input bit em, input bit nt, input bit wk,
                                   input bit sn, output int ph, output int tm);
        int g_t, rg_t;
        g_t  = sn ? TBASE + TEXT : 2 * TBASE;
        rg_t = sn ? TBASE + TEXT : TBASE;
        if ((em || nt) && p == 0) begin ph = 1; tm = TYEL; end
        else if ((em || nt) && p == 2) begin ph = 3; tm = TYEL; end
        else if (em) begin ph = 6; tm = TEXT; end
        else if (nt) begin ph = 5; tm = 1; end
        else begin
            case (p)
                0:       begin ph = 1; tm = TYEL; end
                1:       if (wk) begin ph = 4; tm = TEXT; end else begin ph = 2; tm = rg_t; end
                4:       begin ph = 2; tm = rg_t; end
                2:       begin ph = 3; tm = TYEL; end
                3, 6:    begin ph = 0; tm = g_t; end
                default: begin ph = 3; tm = TYEL; end
            endcase
        end
    endfunction

    // Model state: is a grant offered, is a phase running, ticks seen while running.
    bit m_first = 1, m_valid = 0, m_run = 0, m_fault = 0, m_sens = 0, m_walk = 0;
    int m_ph = 3, m_tm = 0, m_cur = 3, m_ticks = 0;

    always @(posedge clk or posedge reset) begin : model
        bit acc, first, valid, run, flt;
        int ph, tm, cur, tks;
        if (reset) begin
            m_first <= 1; m_valid <= 0; m_run <= 0; m_fault <= 0;
            m_sens <= 0; m_walk <= 0; m_ph <= 3; m_tm <= 0; m_cur <= 3; m_ticks <= 0;
        end else begin
            first = m_first; valid = m_valid; run = m_run; flt = m_fault;
            ph = m_ph; tm = m_tm; cur = m_cur; tks = m_ticks;
            acc = valid && grant_ready;
            if (first) begin
                first = 0; valid = 1; ph = 3; tm = TYEL;
            end else if (acc) begin
                cur = ph; valid = 0; run = 1; tks = 0;
            end else if (run) begin
                if (phase_done) begin
                    run = 0; valid = 1;
                    if (flt) begin ph = 5; tm = 1; end
                    else decide(cur, emerg_req, night_mode, m_walk, m_sens, ph, tm);
                end else if (tick && !flt) begin
                    tks++;
                    if (tks == WDOG) begin
                        flt = 1; run = 0; valid = 1; ph = 5; tm = 1;
                    end
                end
            end
            m_sens  <= sensor || (m_sens && !(acc && m_ph == 2));
            m_walk  <= walk || (m_walk && !(acc && m_ph == 4));
            m_first <= first; m_valid <= valid; m_run <= run; m_fault <= flt;
            m_ph <= ph; m_tm <= tm; m_cur <= cur; m_ticks <= tks;
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("grant_valid", grant_valid, m_valid);
            if (m_valid) begin
                check("grant_phase", grant_phase, m_ph);
                check("grant_time", grant_time, m_tm);
            end
            check("cur_phase", cur_phase, m_cur);
            check("fault", fault, m_fault);
            check("pending", pending, {emerg_req, m_walk, m_sens});
        end
    end

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!grant_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!grant_valid) check({nm, "_timeout"}, 0, 1);
    endtask

    task automatic accept(input int ph, input int tm, input bit sens, input string nm);
        wait_valid(nm);
        check({nm, "_ph"}, grant_phase, ph);
        check({nm, "_t"}, grant_time, tm);
        grant_ready = 1; sensor = sens;
        @(negedge clk);
        grant_ready = 0; sensor = 0;
    endtask

    task automatic finish_ph();
        phase_done = 1;
        @(negedge clk);
        phase_done = 0;
    endtask

    task automatic rand_run(input int n, input int done_mod);
        for (int i = 0; i < n; i++) begin
            grant_ready = ($urandom_range(0, 3) != 0);
            phase_done  = ($urandom_range(0, done_mod - 1) == 0);
            tick        = ($urandom_range(0, 2) == 0);
            sensor      = ($urandom_range(0, 7) == 0);
            walk        = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) emerg_req = ~emerg_req;
            if ($urandom_range(0, 29) == 0) night_mode = ~night_mode;
            reset       = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        reset = 0; grant_ready = 0; phase_done = 0; tick = 0; sensor = 0; walk = 0;
    endtask

    initial begin
        #2 chk_en = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        check("rst_cur", cur_phase, 3);
        // Normal cycle with nothing pending
        accept(3, 2, 0, "t1_ry");  finish_ph();
        accept(0, 12, 0, "t1_gr"); finish_ph();
        accept(1, 2, 0, "t1_yr");  finish_ph();
        accept(2, 6, 0, "t1_rg");  finish_ph();
        accept(3, 2, 0, "t1_ry2"); finish_ph();
        accept(0, 12, 0, "t1_gr2");
        walk = 1; @(negedge clk); walk = 0;
        check("walk_set", pending[1], 1);
        finish_ph();
        // Grant held stable under backpressure
        wait_valid("t2_hold");
        for (int i = 0; i < 5; i++) begin
            walk = ~walk;
            @(negedge clk);
            check("hold_v", grant_valid, 1);
            check("hold_ph", grant_phase, 1);
            check("hold_t", grant_time, 2);
        end
        walk = 0;
        accept(1, 2, 0, "t2_yr"); finish_ph();
        accept(4, 3, 0, "t2_rr");
        check("walk_clr", pending[1], 0);
        finish_ph();
        // Sensor set in its own clearing cycle survives
        accept(2, 6, 1, "t3_rg");
        check("sens_keep", pending[0], 1);
        finish_ph();
        accept(3, 2, 0, "t3_ry");  finish_ph();
        accept(0, 9, 0, "t3_gr");  finish_ph();
        accept(1, 2, 0, "t3_yr");  finish_ph();
        accept(2, 9, 0, "t3_rg2");
        check("sens_clr", pending[0], 0);
        // Emergency preempt
        emerg_req = 1; finish_ph();
        accept(3, 2, 0, "t4_ry");  finish_ph();
        accept(6, 3, 0, "t4_em");  finish_ph();
        accept(6, 3, 0, "t4_em2");
        emerg_req = 0; finish_ph();
        accept(0, 12, 0, "t4_gr");
        // Night flashing
        night_mode = 1; finish_ph();
        accept(1, 2, 0, "t4_yr");  finish_ph();
        accept(5, 1, 0, "t4_fl");  finish_ph();
        accept(5, 1, 0, "t4_fl2");
        night_mode = 0; finish_ph();
        accept(3, 2, 0, "t4_ry2");
        // Watchdog: phase_done withheld
        for (int i = 1; i <= WDOG; i++) begin
            tick = 1;
            @(negedge clk);
            tick = 0;
            check("wd_fault", fault, (i == WDOG) ? 1 : 0);
            if (i < WDOG) begin
                check("wd_idle", grant_valid, 0);
                repeat (2) @(negedge clk);
            end
        end
        accept(5, 1, 0, "t5_fl");
        emerg_req = 1; finish_ph();
        accept(5, 1, 0, "t5_fl2");
        emerg_req = 0;
        // Asynchronous reset mid-phase
        #2 reset = 1;
        #1;
        check("arst_v", grant_valid, 0);
        check("arst_ph", grant_phase, 3);
        check("arst_t", grant_time, 0);
        check("arst_cur", cur_phase, 3);
        check("arst_fault", fault, 0);
        check("arst_pend", pending, 0);
        @(negedge clk); @(negedge clk);
        reset = 0;
        accept(3, 2, 0, "post_rst");
        // Randomized traffic; the second run starves phase_done to reach faults
        rand_run(3000, 6);
        rand_run(3000, 60);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
